// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the regfile_n register file.
//   WOP_*       write-operation encodings driven on the wop port
//   MAX_W       widest register the shared next_value function supports
//   next_value  next register contents for a write op; the write path and the
//               bypass path both call this so they always agree
package regfile_pkg;

    localparam logic [1:0] WOP_NOP  = 2'b00;
    localparam logic [1:0] WOP_LOAD = 2'b01;
    localparam logic [1:0] WOP_INC  = 2'b10;
    localparam logic [1:0] WOP_CLR  = 2'b11;

    // Callers zero-extend into MAX_W bits and keep the low W bits, which
    // makes INC wrap modulo 2^W for any W up to MAX_W.
    localparam int unsigned MAX_W = 64;

    function automatic logic [MAX_W-1:0] next_value(input logic [1:0]       op,
                                                    input logic [MAX_W-1:0] cur,
                                                    input logic [MAX_W-1:0] d);
        case (op)
            WOP_LOAD: return d;
            WOP_INC:  return cur + MAX_W'(1);
            WOP_CLR:  return '0;
            default:  return cur;
        endcase
    endfunction

endpackage

// File: rtl/regfile_n.sv
// regfile_n: N x W register file, one write port (LOAD/INC/CLR) and two
// combinational read ports with an optional write-to-read bypass.
//   ck       clock, rising edge
//   res      asynchronous active-low reset
//   wop      write op: NOP / LOAD / INC / CLR
//   wsel     write register index
//   d        LOAD data
//   rsel_a/b read port indices
//   qa/qb    read data (bypassed when BYPASS=1)
//   r_all    flat stored contents, register i at [i*W +: W], never bypassed
//   ovf      sticky flag, set when an INC wraps all-ones to zero
//   clr_ovf  synchronous clear of ovf (a coincident wrap wins)
// Parameters: W (2..MAX_W), N (power of two, >=2), BYPASS, ZERO_R0.
module regfile_n
    import regfile_pkg::*;
#(
    parameter int unsigned W       = 16,
    parameter int unsigned N       = 4,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic                 ck,
    input  logic                 res,
    input  logic [1:0]           wop,
    input  logic [$clog2(N)-1:0] wsel,
    input  logic [W-1:0]         d,
    input  logic [$clog2(N)-1:0] rsel_a,
    input  logic [$clog2(N)-1:0] rsel_b,
    output logic [W-1:0]         qa,
    output logic [W-1:0]         qb,
    output logic [N*W-1:0]       r_all,
    output logic                 ovf,
    input  logic                 clr_ovf
);

    localparam int unsigned AW = $clog2(N);

    logic [W-1:0]     mem_q [N];
    logic             ovf_q, ovf_d;
    logic             wr_blocked;
    logic             wr_en;
    logic             wrap;
    logic [W-1:0]     cur;
    logic [W-1:0]     nxt;
    logic [MAX_W-1:0] nxt_ext;
    logic [W-1:0]     stored_a, stored_b;

    assign cur     = mem_q[wsel];
    assign nxt_ext = next_value(wop, MAX_W'(cur), MAX_W'(d));
    assign nxt     = nxt_ext[W-1:0];

    if (W < MAX_W) begin : g_nxt_hi
        logic unused_nxt_hi;
        assign unused_nxt_hi = ^nxt_ext[MAX_W-1:W];
    end

    if (ZERO_R0) begin : g_zero_r0
        assign wr_blocked = (wsel == AW'(0));
    end else begin : g_no_zero_r0
        assign wr_blocked = 1'b0;
    end

    // Gated by res so the bypass path also reads 0 while reset is held.
    assign wr_en = res && (wop != WOP_NOP) && !wr_blocked;
    assign wrap  = wr_en && (wop == WOP_INC) && (cur == '1);

    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (wrap)    ovf_d = 1'b1;
    end

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            for (int unsigned i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            if (wr_en) mem_q[wsel] <= nxt;
            ovf_q <= ovf_d;
        end
    end

    assign stored_a = mem_q[rsel_a];
    assign stored_b = mem_q[rsel_b];

    if (BYPASS) begin : g_bypass
        assign qa = (wr_en && (rsel_a == wsel)) ? nxt : stored_a;
        assign qb = (wr_en && (rsel_b == wsel)) ? nxt : stored_b;
    end else begin : g_no_bypass
        assign qa = stored_a;
        assign qb = stored_b;
    end

    for (genvar i = 0; i < N; i++) begin : g_r_all
        assign r_all[i*W +: W] = mem_q[i];
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_regfile_n.sv
// tb_regfile_n: checks three regfile_n configurations against an array-based
// reference model: A = defaults, B = BYPASS=0/ZERO_R0=1 (same stimulus as A),
// C = N=8, W=8 with its own stimulus.
module tb_regfile_n;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    // A and B share stimulus
    logic        res, clr_ovf;
    logic [1:0]  wop, wsel, rsel_a, rsel_b;
    logic [15:0] d;
    logic [15:0] qa_a, qb_a, qa_b, qb_b;
    logic [63:0] r_all_a, r_all_b;
    logic        ovf_a, ovf_b;

    logic        c_res, c_clr_ovf;
    logic [1:0]  c_wop;
    logic [2:0]  c_wsel, c_rsel_a, c_rsel_b;
    logic [7:0]  c_d, qa_c, qb_c;
    logic [63:0] r_all_c;
    logic        ovf_c;

    regfile_n dut_a (
        .ck(ck), .res(res), .wop(wop), .wsel(wsel), .d(d), .rsel_a(rsel_a), .rsel_b(rsel_b),
        .qa(qa_a), .qb(qb_a), .r_all(r_all_a), .ovf(ovf_a), .clr_ovf(clr_ovf)
    );

    regfile_n #(.W(16), .N(4), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_b (
        .ck(ck), .res(res), .wop(wop), .wsel(wsel), .d(d), .rsel_a(rsel_a), .rsel_b(rsel_b),
        .qa(qa_b), .qb(qb_b), .r_all(r_all_b), .ovf(ovf_b), .clr_ovf(clr_ovf)
    );

    regfile_n #(.W(8), .N(8), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_c (
        .ck(ck), .res(c_res), .wop(c_wop), .wsel(c_wsel), .d(c_d), .rsel_a(c_rsel_a),
        .rsel_b(c_rsel_b), .qa(qa_c), .qb(qb_c), .r_all(r_all_c), .ovf(ovf_c),
        .clr_ovf(c_clr_ovf)
    );

    // ---------------- reference model ----------------
    int          cfg_w   [3] = '{16, 16, 8};
    int          cfg_n   [3] = '{4, 4, 8};
    bit          cfg_byp [3] = '{1'b1, 1'b0, 1'b1};
    bit          cfg_z   [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] mdl     [3][8];
    logic        movf    [3];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mask_of(input int id);
        return 16'hFFFF >> (16 - cfg_w[id]);
    endfunction

    function automatic logic [15:0] nextv(input int id, input logic [1:0] op, input int ws,
                                          input logic [15:0] dd);
        case (op)
            2'd1:    return dd & mask_of(id);
            2'd2:    return (mdl[id][ws] + 16'd1) & mask_of(id);
            2'd3:    return 16'd0;
            default: return mdl[id][ws];
        endcase
    endfunction

    function automatic logic [15:0] exp_read(input int id, input logic [1:0] op, input int ws,
                                             input logic [15:0] dd, input int rs, input logic r);
        if (!r) return 16'd0;
        if (cfg_z[id] && rs == 0) return 16'd0;
        if (cfg_byp[id] && op != 2'd0 && rs == ws && !(cfg_z[id] && ws == 0))
            return nextv(id, op, ws, dd);
        return mdl[id][rs];
    endfunction

    function automatic logic [63:0] exp_all(input int id);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < cfg_n[id]; i++) v |= 64'(mdl[id][i]) << (i * cfg_w[id]);
        return v;
    endfunction

    task automatic model_reset(input int id);
        for (int i = 0; i < 8; i++) mdl[id][i] = 16'd0;
        movf[id] = 1'b0;
    endtask

    task automatic model_edge(input int id, input logic [1:0] op, input int ws,
                              input logic [15:0] dd, input logic clr);
        logic ignored, wrapped;
        ignored = (op == 2'd0) || (cfg_z[id] && ws == 0);
        wrapped = !ignored && op == 2'd2 && mdl[id][ws] == mask_of(id);
        if (!ignored) mdl[id][ws] = nextv(id, op, ws, dd);
        if (wrapped) movf[id] = 1'b1;
        else if (clr) movf[id] = 1'b0;
    endtask

    always @(posedge ck) begin
        if (res) begin
            model_edge(0, wop, int'(wsel), d, clr_ovf);
            model_edge(1, wop, int'(wsel), d, clr_ovf);
        end
        if (c_res) model_edge(2, c_wop, int'(c_wsel), 16'(c_d), c_clr_ovf);
    end

    // Drive one cycle at the falling edge, then check pre-edge outputs.
    task automatic run_ab(input logic r, input logic [1:0] op, input int ws,
                          input logic [15:0] dd, input int ra, input int rb, input logic clr);
        @(negedge ck);
        res = r; wop = op; wsel = 2'(ws); d = dd;
        rsel_a = 2'(ra); rsel_b = 2'(rb); clr_ovf = clr;
        if (!r) begin model_reset(0); model_reset(1); end
        #1;
        check_eq("a_qa",   64'(qa_a), 64'(exp_read(0, op, ws, dd, ra, r)));
        check_eq("a_qb",   64'(qb_a), 64'(exp_read(0, op, ws, dd, rb, r)));
        check_eq("a_rall", r_all_a,   exp_all(0));
        check_eq("a_ovf",  64'(ovf_a), 64'(movf[0]));
        check_eq("b_qa",   64'(qa_b), 64'(exp_read(1, op, ws, dd, ra, r)));
        check_eq("b_qb",   64'(qb_b), 64'(exp_read(1, op, ws, dd, rb, r)));
        check_eq("b_rall", r_all_b,   exp_all(1));
        check_eq("b_ovf",  64'(ovf_b), 64'(movf[1]));
    endtask

    task automatic run_c(input logic r, input logic [1:0] op, input int ws,
                         input logic [7:0] dd, input int ra, input int rb, input logic clr);
        @(negedge ck);
        c_res = r; c_wop = op; c_wsel = 3'(ws); c_d = dd;
        c_rsel_a = 3'(ra); c_rsel_b = 3'(rb); c_clr_ovf = clr;
        if (!r) model_reset(2);
        #1;
        check_eq("c_qa",   64'(qa_c), 64'(exp_read(2, op, ws, 16'(dd), ra, r)));
        check_eq("c_qb",   64'(qb_c), 64'(exp_read(2, op, ws, 16'(dd), rb, r)));
        check_eq("c_rall", r_all_c,   exp_all(2));
        check_eq("c_ovf",  64'(ovf_c), 64'(movf[2]));
    endtask

    initial begin
        res = 1'b0; wop = 2'd0; wsel = 2'd0; d = 16'd0;
        rsel_a = 2'd0; rsel_b = 2'd0; clr_ovf = 1'b0;
        c_res = 1'b0; c_wop = 2'd0; c_wsel = 3'd0; c_d = 8'd0;
        c_rsel_a = 3'd0; c_rsel_b = 3'd0; c_clr_ovf = 1'b0;
        for (int i = 0; i < 3; i++) model_reset(i);

        // Reset held with a LOAD r3 pending
        run_ab(1'b0, 2'd1, 3, 16'h1234, 3, 3, 1'b0);
        run_ab(1'b0, 2'd1, 3, 16'h1234, 3, 3, 1'b0);
        check_eq("rst_qa", 64'(qa_a), 64'd0);
        check_eq("rst_rall", r_all_a, 64'd0);
        run_ab(1'b1, 2'd1, 3, 16'h1234, 3, 3, 1'b0);
        run_ab(1'b1, 2'd0, 0, 16'h0000, 3, 0, 1'b0);
        check_eq("rst_r3", 64'(r_all_a[63:48]), 64'h1234);

        // Load / read
        for (int i = 0; i < 4; i++) run_ab(1'b1, 2'd1, i, 16'(i + 1), 0, 0, 1'b0);
        run_ab(1'b1, 2'd0, 0, 16'h0, 2, 3, 1'b0);
        check_eq("ld_qa", 64'(qa_a), 64'd3);
        check_eq("ld_qb", 64'(qb_a), 64'd4);
        check_eq("ld_rall", r_all_a, 64'h0004_0003_0002_0001);

        // Wrap, then INC with clr_ovf
        run_ab(1'b1, 2'd1, 1, 16'hFFFE, 0, 1, 1'b0);
        run_ab(1'b1, 2'd2, 1, 16'h0, 0, 1, 1'b0);
        run_ab(1'b1, 2'd2, 1, 16'h0, 0, 1, 1'b0);
        run_ab(1'b1, 2'd0, 0, 16'h0, 0, 1, 1'b0);
        check_eq("wrap_r1", 64'(r_all_a[31:16]), 64'h0000);
        check_eq("wrap_ovf", 64'(ovf_a), 64'd1);
        run_ab(1'b1, 2'd2, 1, 16'h0, 0, 1, 1'b1);
        run_ab(1'b1, 2'd0, 0, 16'h0, 0, 1, 1'b0);
        check_eq("clr_r1", 64'(r_all_a[31:16]), 64'h0001);
        check_eq("clr_ovf", 64'(ovf_a), 64'd0);

        // Bypass vs no bypass
        run_ab(1'b1, 2'd1, 2, 16'd7, 0, 0, 1'b0);
        run_ab(1'b1, 2'd2, 2, 16'd0, 2, 2, 1'b0);
        check_eq("byp_qa", 64'(qa_a), 64'd8);
        check_eq("byp_qb", 64'(qb_a), 64'd8);
        check_eq("byp_rall", 64'(r_all_a[47:32]), 64'd7);
        check_eq("nobyp_qa", 64'(qa_b), 64'd7);

        // ZERO_R0 on B: r0 stays 0, no ovf from r0
        run_ab(1'b1, 2'd1, 0, 16'h55, 0, 0, 1'b0);
        check_eq("z_qa", 64'(qa_b), 64'd0);
        for (int i = 0; i < 3; i++) run_ab(1'b1, 2'd2, 0, 16'h0, 0, 0, 1'b0);
        run_ab(1'b1, 2'd0, 0, 16'h0, 0, 0, 1'b0);
        check_eq("z_r0", 64'(r_all_b[15:0]), 64'd0);
        check_eq("z_ovf", 64'(ovf_b), 64'd0);

        // Randomized A/B, with occasional reset cycles
        for (int k = 0; k < 400; k++) begin
            logic [15:0] rd;
            rd = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            run_ab(($urandom_range(0, 63) != 0), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 3), rd, $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0));
        end

        // C: N=8, W=8
        run_c(1'b0, 2'd0, 0, 8'h0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) run_c(1'b1, 2'd2, 5, 8'h0, 5, 0, 1'b0);
        run_c(1'b1, 2'd0, 0, 8'h0, 5, 5, 1'b0);
        check_eq("c_inc3", 64'(r_all_c[47:40]), 64'd3);
        run_c(1'b1, 2'd3, 5, 8'h0, 5, 0, 1'b0);
        check_eq("c_clr_byp", 64'(qa_c), 64'd0);
        run_c(1'b1, 2'd1, 7, 8'hFF, 0, 0, 1'b0);
        run_c(1'b1, 2'd2, 7, 8'h0, 7, 0, 1'b0);
        run_c(1'b1, 2'd1, 5, 8'hAA, 5, 7, 1'b0);
        run_c(1'b1, 2'd0, 0, 8'h0, 5, 7, 1'b0);
        check_eq("c_r5", 64'(r_all_c[47:40]), 64'hAA);
        check_eq("c_ovf_set", 64'(ovf_c), 64'd1);
        // Reset pulse between edges, with a LOAD pending
        c_wop = 2'd1; c_wsel = 3'd6; c_d = 8'h77; c_rsel_a = 3'd6;
        #1 c_res = 1'b0;
        model_reset(2);
        #1;
        check_eq("c_pulse_rall", r_all_c, 64'd0);
        check_eq("c_pulse_ovf", 64'(ovf_c), 64'd0);
        check_eq("c_pulse_qa", 64'(qa_c), 64'd0);
        c_res = 1'b1;
        for (int k = 0; k < 200; k++) begin
            logic [7:0] rd;
            rd = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            run_c(1'b1, 2'($urandom_range(0, 3)), $urandom_range(0, 7), rd,
                  $urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_n.md
# regfile_n

Parametrised multi-port register file for the calculator datapath, successor to the fixed 4×16-bit `regfile`. It holds N registers of W bits with one write port and two independent read ports. The write port supports load, increment and clear operations, and an optional read bypass. All register contents are exported flat for display and debug.

## Interface
Parameters:
- `W`, 16, register width in bits (≥2)
- `N`, 4, number of registers (power of two, ≥2); `AW = $clog2(N)`
- `BYPASS`, 1, 1 = read ports return the value being written this cycle; 0 = read ports return the stored value
- `ZERO_R0`, 0, 1 = register 0 is hardwired to 0 and writes to it are ignored

Ports:
- `ck`  in  1  clock, rising edge
- `res`  in  1  reset, asynchronous, active-low
- `wop`  in  2  write operation: 00 NOP, 01 LOAD, 10 INC, 11 CLR
- `wsel`  in  AW  write register index
- `d`  in  W  LOAD data
- `rsel_a`  in  AW  read port A index
- `rsel_b`  in  AW  read port B index
- `qa`  out  W  read port A data (combinational)
- `qb`  out  W  read port B data (combinational)
- `r_all`  out  N*W  all registers; register i occupies bits [i*W +: W]
- `ovf`  out  1  sticky increment-wrap flag
- `clr_ovf`  in  1  synchronous clear of `ovf`

## Operation
- **Reset:** `res`=0 immediately forces every register and `ovf` to 0.
  - Consequently `qa`, `qb` and `r_all` read 0 while reset is held and after release.
  - Reset asserted mid-operation discards the pending write.
- **Write operations** are evaluated at the rising edge of `ck` when `res`=1:
  - LOAD: `r[wsel] <= d`
  - INC: `r[wsel] <= r[wsel] + 1`, modulo 2^W. If the old value was all-ones, the register wraps to 0 and `ovf` <= 1.
  - CLR: `r[wsel] <= 0`
  - NOP: no change
- **Write to register 0 with `ZERO_R0`=1:** the write is ignored and `ovf` is not set by it. `r[0]` always reads 0.
- **`ovf` update:**
  - `clr_ovf`=1 clears `ovf` at the edge.
  - If `clr_ovf` coincides with a wrapping INC, the set wins and `ovf`=1.
- **Reads:** `qa = r[rsel_a]` and `qb = r[rsel_b]`, combinational.
  - Both ports may address the same register, including the one being written.
- **Bypass (`BYPASS`=1):**
  - Applies when `rsel_x == wsel` and `wop` != NOP.
  - The port then shows the next value: `d` for LOAD, `r+1` for INC, 0 for CLR.
  - Bypass is suppressed for register 0 when `ZERO_R0`=1.
- **`r_all`:** always reflects stored contents and is never bypassed.

## Timing
- Write latency: 1 cycle. A value written at edge k is visible on `r_all` and on non-bypassed reads after edge k.
- Bypass: the read path is combinational from `wop`/`wsel`/`d`/`rsel` to `qa`/`qb` in the same cycle.
- Inputs must be stable around the rising edge of `ck`. There is no handshake; one operation may be issued every cycle.
- Back-to-back INC on the same register increments every cycle. N consecutive INCs from value v yield v+N mod 2^W.
- `res` deassertion is asynchronous to `ck`. The first write takes effect at the first rising edge with `res`=1.

## Structure
- Shared package `regfile_pkg` holds:
  - `wop` encodings as localparams: `WOP_NOP`, `WOP_LOAD`, `WOP_INC`, `WOP_CLR`
  - a `next_value(op, cur, d)` function, used by both the write path and the bypass path so the two cannot diverge
- No sub-module is required.
- Storage is a W-bit array of N entries, with a generate loop producing `r_all`.
- `ZERO_R0` and `BYPASS` are elaborated with generate-if, not runtime muxes.

## Test plan
Default parameters unless stated.
1. **Reset:** hold `res`=0 for 2 cycles, then LOAD 0x1234 → r3 at the same time → `r_all`=0, `qa`=`qb`=0 during reset; after release, the first LOAD at the next edge shows `r3`=0x1234.
2. **Load/read:** LOAD r0=1, r1=2, r2=3, r3=4 → with `rsel_a`=2, `rsel_b`=3: `qa`=3, `qb`=4; `r_all`=0x0004_0003_0002_0001.
3. **Wrap:** LOAD r1=0xFFFE, then INC, INC → r1=0xFFFF, then 0x0000; `ovf` rises after the second INC. Next, INC with `clr_ovf`=1 on r1 (no wrap) → r1=1, `ovf`=0.
4. **Bypass:** r2=7, and in one cycle INC r2 with `rsel_a`=`rsel_b`=2 → `qa`=`qb`=8 before the edge, `r_all` slice still 7. With `BYPASS`=0 the same stimulus gives 7 before the edge.
5. **ZERO_R0=1:** LOAD r0=0x55 and INC r0 from 0 repeatedly → r0 stays 0, `qa`(rsel 0)=0, `ovf` stays 0.
6. **Mid-operation reset and CLR, N=8, W=8:** INC r5 ×3 → 3; CLR r5 → 0; LOAD r5=0xAA then pulse `res` low between edges → r5=0, `ovf`=0 immediately, before the next edge.
